pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 105 ++++++++++
 tb/tb_pixel_streamer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer: raster-order reader from a synchronous pixel RAM feeding a 5x5 filter,
// with a one-entry skid register so downstream hold never drops or repeats a pixel.
module pixel_streamer #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        Din,
    output logic              data_valid,
    output logic              line_end,
    output logic              frame_end,
    output logic              busy,
    output logic              done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(N + 1);
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_rd_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic              r_skid_v;
    logic [7:0]        r_skid;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;

    logic       w_issue;
    logic       w_emit;
    logic       w_last_x;
    logic       w_last_y;
    logic [7:0] w_pix;

    // rst gates the strobe so no read is launched in the reset cycle itself
    assign w_issue  = !rst && r_state == STREAM && !hold && r_rd_cnt < CW'(N);
    assign mem_rd   = w_issue;
    assign mem_addr = w_issue ? ADDR_W'(r_rd_cnt) : r_addr;
    assign w_emit   = !hold && (r_skid_v || r_pend);
    assign w_pix    = r_skid_v ? r_skid : mem_data;
    assign w_last_x = r_x == XW'(IMG_W - 1);
    assign w_last_y = r_y == YW'(IMG_H - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rd_cnt   <= '0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_skid_v   <= 1'b0;
            r_skid     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            Din        <= '0;
            data_valid <= 1'b0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_pend     <= w_issue;
            data_valid <= w_emit;
            line_end   <= w_emit && w_last_x;
            frame_end  <= w_emit && w_last_x && w_last_y;
            done       <= 1'b0;
            if (w_issue) begin
                r_addr   <= ADDR_W'(r_rd_cnt);
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
            if (w_emit) begin
                Din <= w_pix;
                r_x <= w_last_x ? '0 : r_x + XW'(1);
                if (w_last_x)
                    r_y <= w_last_y ? '0 : r_y + YW'(1);
            end
            // a read can only return under hold when the skid is empty, since hold blocks new issues
            r_skid_v <= hold && (r_skid_v || r_pend);
            if (hold && r_pend)
                r_skid <= mem_data;
            if (r_state == IDLE) begin
                if (start && !done) begin
                    r_state  <= STREAM;
                    busy     <= 1'b1;
                    r_rd_cnt <= '0;
                end
            end else if (r_state == STREAM) begin
                if (w_issue && r_rd_cnt == CW'(N - 1))
                    r_state <= DRAIN;
            end else if (frame_end) begin
                r_state <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: randomized-hold scoreboard bench; expected pixels are pushed per started
// frame and popped by an independent monitor whenever data_valid is seen.
module tb_pixel_streamer;
    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst, start, hold;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] Din;
    logic       data_valid, line_end, frame_end, busy, done;

    typedef struct {
        logic [7:0] d;
        logic       le;
        logic       fe;
    } px_t;

    px_t  sb[$];
    px_t  m_e;
    int   errs = 0;
    int   checks = 0;
    int   exp_addr = 0;
    logic prev_fe = 1'b0;
    int   f, fe, d;

    pixel_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .Din(Din), .data_valid(data_valid), .line_end(line_end),
        .frame_end(frame_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd) mem_data <= {2'b00, mem_addr} + 8'h10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) prev_fe = 1'b0;
        else begin
            if (data_valid) begin
                if (sb.size() == 0) chk("extra_pixel", 1, 0);
                else begin
                    m_e = sb.pop_front();
                    chk("din", Din, m_e.d);
                    chk("line_end", line_end, m_e.le);
                    chk("frame_end", frame_end, m_e.fe);
                end
            end
            if (mem_rd) begin
                chk("mem_addr", mem_addr, exp_addr);
                exp_addr++;
            end
            if (prev_fe || done) begin
                chk("done_after_frame_end", done, prev_fe);
                if (prev_fe) chk("busy_drop", busy, 0);
            end
            prev_fe = frame_end;
        end
    end

    function automatic logic hold_at(input int mode, input int c);
        case (mode)
            1:       return c >= 6 && c <= 9;
            2:       return (c % 2) == 1;
            3:       return $urandom_range(0, 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_frame();
        exp_addr = 0;
        for (int i = 0; i < W * H; i++)
            sb.push_back(px_t'{d: 8'(i + 16), le: (i % W) == W - 1, fe: i == W * H - 1});
    endtask

    task automatic run_frame(input int mode, input int extra_start,
                             output int first_dv, output int fe_cyc, output int done_cyc);
        first_dv = -1;
        fe_cyc   = -1;
        done_cyc = -1;
        push_frame();
        start = 1'b1;
        hold  = hold_at(mode, 0);
        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            start = (c == extra_start);
            hold  = hold_at(mode, c);
            if (data_valid && first_dv < 0) first_dv = c;
            if (frame_end) fe_cyc = c;
            if (done) done_cyc = c;
        end
        hold = 1'b0;
        if (done_cyc < 0) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_line_end"}, line_end, 0);
        chk({tag, "_frame_end"}, frame_end, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_din"}, Din, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, -1, f, fe, d);
        chk("first_pixel_cycle", f, 3);
        chk("plain_frame_end_cycle", fe, 66);
        chk("plain_done_cycle", d, 67);
        chk("plain_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        run_frame(1, -1, f, fe, d);
        chk("hold_window_frame_end_cycle", fe, 70);
        chk("hold_window_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        run_frame(2, -1, f, fe, d);
        chk("toggle_frame_time_ok", d <= 2 * 67 + 2, 1);
        chk("toggle_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            run_frame(3, -1, f, fe, d);
            chk("random_hold_sb_empty", sb.size(), 0);
            @(posedge clk); #1;
        end

        run_frame(0, 20, f, fe, d);
        chk("restart_ignored_frame_end_cycle", fe, 66);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_on_done_ignored", busy, 0);
        run_frame(0, -1, f, fe, d);
        chk("start_after_done_frame_end_cycle", fe, 66);
        chk("start_after_done_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        push_frame();
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 30) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("midframe_reset");
        sb.delete();
        repeat (6) @(posedge clk);
        #1;
        run_frame(0, -1, f, fe, d);
        chk("after_reset_frame_end_cycle", fe, 66);
        chk("after_reset_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("start_with_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_with_rst_idle", {busy, mem_rd, data_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
